// File: rtl/mpp_ram_pkg.sv
// Shared types and constants for the MPP RAM access path.
// Contents:
//   RAM_AW / RAM_DW / RAM_LEN_W  address, data and burst-length widths
//   RW_READ / RW_WRITE           encoding of the RAM rw pin
//   ram_state_e                  phase state of the access controller
package mpp_ram_pkg;

   localparam int unsigned RAM_AW    = 8;
   localparam int unsigned RAM_DW    = 8;
   localparam int unsigned RAM_LEN_W = 5;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_FIN
   } ram_state_e;

endpackage

// File: rtl/ram_burst_counter.sv
// Burst address/length tracker for ram_access_ctrl.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         capture base_addr/len as a new burst
//   step         advance to the next word (address wraps modulo 2^AW)
//   base_addr    first word address
//   len          number of words in the burst
//   cur_addr     address of the word being accessed (registered)
//   last_c       current word is the final one of the burst (combinational)
module ram_burst_counter
   import mpp_ram_pkg::*;
#(
   parameter int unsigned AW = RAM_AW,
   parameter int unsigned LW = RAM_LEN_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len,
   output logic [AW-1:0] cur_addr,
   output logic          last_c
);

   logic [LW-1:0] remaining;

   // Load wins over step; the address simply rolls over at the top of the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         remaining <= '0;
      end else if (load) begin
         cur_addr  <= base_addr;
         remaining <= len;
      end else if (step) begin
         cur_addr  <= cur_addr + AW'(1);
         remaining <= remaining - LW'(1);
      end
   end

   // remaining counts the current word, so one left means this is the last.
   assign last_c = (remaining <= LW'(1));

endmodule

// File: rtl/ram_access_ctrl.sv
// Bus-side initiator for the 256x8 ram_storage array.
// Runs single/burst reads and writes requested over start/busy/done and drives
// the level-sensitive RAM pins with setup / strobe / hold phasing so that the
// address, direction and write data are stable around every chip-select pulse.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, wr, base_addr,   request; sampled only in IDLE
//   len
//   wdata, wdata_ack        write-data stream; ack means wdata was consumed
//   rdata, rdata_valid      read-data stream; rdata holds until the next read
//   busy, done              request in flight / end-of-burst pulse
//   ram_cs, ram_rw,         RAM pins (cs active high, rw 1 = read)
//   ram_addr, ram_wdata
//   ram_rdata               RAM data_out, valid while cs=1 and rw=1
// Every output is a flop loaded from the current state, so the pins lag the
// FSM state by one cycle: cs is high in the cycle after ST_STROBE.
module ram_access_ctrl
   import mpp_ram_pkg::*;
#(
   parameter int unsigned AW = RAM_AW,
   parameter int unsigned DW = RAM_DW,
   parameter int unsigned LW = RAM_LEN_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          wr,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len,
   input  logic [DW-1:0] wdata,
   output logic          wdata_ack,
   output logic [DW-1:0] rdata,
   output logic          rdata_valid,
   output logic          busy,
   output logic          done,
   output logic          ram_cs,
   output logic          ram_rw,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   ram_state_e    state;
   ram_state_e    state_nxt;
   logic          wr_q;
   logic          wr_nxt;

   logic          cnt_load_c;
   logic          cnt_step_c;
   logic [AW-1:0] cur_addr;
   logic          last_c;

   logic          wdata_ack_nxt;
   logic [DW-1:0] rdata_nxt;
   logic          rdata_valid_nxt;
   logic          busy_nxt;
   logic          done_nxt;
   logic          ram_cs_nxt;
   logic          ram_rw_nxt;
   logic [AW-1:0] ram_addr_nxt;
   logic [DW-1:0] ram_wdata_nxt;

   ram_burst_counter #(
      .AW (AW),
      .LW (LW)
   ) u_burst_counter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (cnt_load_c),
      .step      (cnt_step_c),
      .base_addr (base_addr),
      .len       (len),
      .cur_addr  (cur_addr),
      .last_c    (last_c)
   );

   // State and output registers; reset drops cs at once and abandons any burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         wr_q        <= 1'b0;
         wdata_ack   <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_cs      <= 1'b0;
         ram_rw      <= RW_READ;
         ram_addr    <= '0;
         ram_wdata   <= '0;
      end else begin
         state       <= state_nxt;
         wr_q        <= wr_nxt;
         wdata_ack   <= wdata_ack_nxt;
         rdata       <= rdata_nxt;
         rdata_valid <= rdata_valid_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         ram_cs      <= ram_cs_nxt;
         ram_rw      <= ram_rw_nxt;
         ram_addr    <= ram_addr_nxt;
         ram_wdata   <= ram_wdata_nxt;
      end
   end

   // Next state and next output values; pins hold unless a phase changes them.
   always_comb begin
      state_nxt       = state;
      wr_nxt          = wr_q;
      cnt_load_c      = 1'b0;
      cnt_step_c      = 1'b0;
      wdata_ack_nxt   = 1'b0;
      rdata_nxt       = rdata;
      rdata_valid_nxt = 1'b0;
      busy_nxt        = busy;
      done_nxt        = 1'b0;
      ram_cs_nxt      = 1'b0;
      ram_rw_nxt      = ram_rw;
      ram_addr_nxt    = ram_addr;
      ram_wdata_nxt   = ram_wdata;

      unique case (state)
         ST_IDLE: begin
            ram_rw_nxt = RW_READ;
            busy_nxt   = 1'b0;
            if (start) begin
               wr_nxt     = wr;
               cnt_load_c = 1'b1;
               busy_nxt   = 1'b1;
               state_nxt  = (len == LW'(0)) ? ST_FIN : ST_SETUP;
            end
         end

         // Address, direction and write data settle while cs is low.
         ST_SETUP: begin
            ram_addr_nxt = cur_addr;
            ram_rw_nxt   = wr_q ? RW_WRITE : RW_READ;
            if (wr_q) begin
               ram_wdata_nxt = wdata;
               wdata_ack_nxt = 1'b1;
            end
            state_nxt = ST_STROBE;
         end

         ST_STROBE: begin
            ram_cs_nxt = 1'b1;
            state_nxt  = ST_HOLD;
         end

         // cs is high on the pins during this state, so read data is valid now.
         ST_HOLD: begin
            if (!wr_q) begin
               rdata_nxt       = ram_rdata;
               rdata_valid_nxt = 1'b1;
            end
            cnt_step_c = 1'b1;
            state_nxt  = last_c ? ST_FIN : ST_SETUP;
         end

         ST_FIN: begin
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            ram_rw_nxt = RW_READ;
            state_nxt  = ST_IDLE;
         end

         default: begin
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 256x8 RAM and a
// pin-stability checker around every chip-select pulse.
module tb_ram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] base_addr = 8'h00;
   logic [4:0] len = 5'd0;
   logic [7:0] wdata = 8'h00;
   logic       wdata_ack;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       busy;
   logic       done;
   logic       ram_cs;
   logic       ram_rw;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;

   int checks = 0;
   int errors = 0;

   ram_access_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .wr          (wr),
      .base_addr   (base_addr),
      .len         (len),
      .wdata       (wdata),
      .wdata_ack   (wdata_ack),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .busy        (busy),
      .done        (done),
      .ram_cs      (ram_cs),
      .ram_rw      (ram_rw),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clk = ~clk;

   // ram_storage model: write while cs=1 and rw=0, combinational read data.
   logic [7:0] mem [256] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_cs && !ram_rw) mem[ram_addr] <= ram_wdata;
   end
   assign ram_rdata = (ram_cs && ram_rw) ? mem[ram_addr] : 8'h00;

   // Pin-stability checker, sampled mid-cycle.
   logic       p_ok = 1'b0;
   logic       p_cs;
   logic       p_rw;
   logic [7:0] p_addr;
   logic [7:0] p_wdata;
   always @(negedge clk) begin
      if (!rst_n) begin
         p_ok = 1'b0;
      end else begin
         if (p_ok && (ram_cs || p_cs)) begin
            checks++;
            assert (ram_addr === p_addr && ram_rw === p_rw && ram_wdata === p_wdata) else begin
               errors++;
               $error("FAIL pin_stable observed=%h/%b/%h expected=%h/%b/%h",
                      ram_addr, ram_rw, ram_wdata, p_addr, p_rw, p_wdata);
            end
         end
         if (p_ok && ram_cs) begin
            checks++;
            assert (p_cs === 1'b0) else begin
               errors++;
               $error("FAIL cs_back_to_back observed=%b expected=%b", p_cs, 1'b0);
            end
         end
         p_cs    = ram_cs;
         p_rw    = ram_rw;
         p_addr  = ram_addr;
         p_wdata = ram_wdata;
         p_ok    = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Burst results.
   logic [7:0] wq [32];
   logic [7:0] rq [32];
   int lat;
   int n_ack;
   int n_val;
   int n_done;
   int n_cs;
   int n_busy;

   // Issue one request; lat counts cycles from the start cycle to the done cycle.
   task automatic run_burst(input logic w, input logic [7:0] b, input logic [4:0] l,
                            input bit hold);
      int widx;
      widx = 0; n_ack = 0; n_val = 0; n_done = 0; n_cs = 0; n_busy = 0; lat = 0;
      @(negedge clk);
      wr = w; base_addr = b; len = l; wdata = wq[0]; start = 1'b1;
      @(negedge clk);
      lat = 1;
      if (!hold) start = 1'b0;
      while (lat <= 200) begin
         if (wdata_ack) begin
            n_ack++;
            widx++;
            wdata = wq[widx[4:0]];
         end
         if (rdata_valid) begin
            rq[n_val[4:0]] = rdata;
            n_val++;
         end
         if (ram_cs) n_cs++;
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            start = 1'b0;
            break;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) n_done++;
         if (rdata_valid) n_val++;
         if (ram_cs) n_cs++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [7:0] m80;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(ram_cs), 32'd0);
      chk("rst_rw", 32'(ram_rw), 32'd1);
      chk("rst_addr", 32'(ram_addr), 32'h00);
      chk("rst_wdata", 32'(ram_wdata), 32'h00);
      chk("rst_rdata", 32'(rdata), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ack", 32'(wdata_ack), 32'd0);
      chk("rst_valid", 32'(rdata_valid), 32'd0);
      rst_n = 1'b1;

      // 1: single write then single read
      wq[0] = 8'hA5; wq[1] = 8'h00;
      run_burst(1'b1, 8'h10, 5'd1, 1'b0);
      chk("t1_wr_lat", 32'(lat), 32'd5);
      chk("t1_wr_ack", 32'(n_ack), 32'd1);
      chk("t1_wr_done", 32'(n_done), 32'd1);
      chk("t1_wr_cs", 32'(n_cs), 32'd1);
      chk("t1_mem10", 32'(mem[8'h10]), 32'hA5);
      run_burst(1'b0, 8'h10, 5'd1, 1'b0);
      chk("t1_rd_lat", 32'(lat), 32'd5);
      chk("t1_rd_valid", 32'(n_val), 32'd1);
      chk("t1_rd_data", 32'(rq[0]), 32'hA5);
      chk("t1_rdata_hold", 32'(rdata), 32'hA5);
      chk("t1_rw_idle", 32'(ram_rw), 32'd1);

      // 2: wrapping write burst and read back
      wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44; wq[4] = 8'h00;
      run_burst(1'b1, 8'hFE, 5'd4, 1'b0);
      chk("t2_wr_lat", 32'(lat), 32'd14);
      chk("t2_wr_ack", 32'(n_ack), 32'd4);
      chk("t2_memFE", 32'(mem[8'hFE]), 32'h11);
      chk("t2_memFF", 32'(mem[8'hFF]), 32'h22);
      chk("t2_mem00", 32'(mem[8'h00]), 32'h33);
      chk("t2_mem01", 32'(mem[8'h01]), 32'h44);
      chk("t2_mem02", 32'(mem[8'h02]), 32'h00);
      run_burst(1'b0, 8'hFE, 5'd4, 1'b0);
      chk("t2_rd_lat", 32'(lat), 32'd14);
      chk("t2_rd_valid", 32'(n_val), 32'd4);
      chk("t2_rd_ack", 32'(n_ack), 32'd0);
      chk("t2_rd0", 32'(rq[0]), 32'h11);
      chk("t2_rd1", 32'(rq[1]), 32'h22);
      chk("t2_rd2", 32'(rq[2]), 32'h33);
      chk("t2_rd3", 32'(rq[3]), 32'h44);

      // 3: zero-length request
      run_burst(1'b1, 8'h20, 5'd0, 1'b0);
      chk("t3_lat", 32'(lat), 32'd2);
      chk("t3_cs", 32'(n_cs), 32'd0);
      chk("t3_busy", 32'(n_busy), 32'd1);
      chk("t3_done", 32'(n_done), 32'd1);
      chk("t3_ack", 32'(n_ack), 32'd0);

      // 4: start held high through a len=3 read
      wq[0] = 8'h5A; wq[1] = 8'h6B; wq[2] = 8'h7C; wq[3] = 8'h00;
      run_burst(1'b1, 8'h40, 5'd3, 1'b0);
      chk("t4_wr_lat", 32'(lat), 32'd11);
      run_burst(1'b0, 8'h40, 5'd3, 1'b1);
      chk("t4_lat", 32'(lat), 32'd11);
      chk("t4_done", 32'(n_done), 32'd1);
      chk("t4_valid", 32'(n_val), 32'd3);
      chk("t4_rd0", 32'(rq[0]), 32'h5A);
      chk("t4_rd1", 32'(rq[1]), 32'h6B);
      chk("t4_rd2", 32'(rq[2]), 32'h7C);

      // 5: reset while cs is high during a write burst
      wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03; wq[3] = 8'h04;
      @(negedge clk);
      wr = 1'b1; base_addr = 8'h80; len = 5'd4; wdata = wq[0]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (ram_cs) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("t5_cs_seen", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_cs", 32'(ram_cs), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("t5_no_done", 32'(n_done), 32'd0);
      m80 = mem[8'h80];
      chk("t5_mem80_ok", 32'((m80 == 8'h00) || (m80 == 8'h01)), 32'd1);
      chk("t5_mem81", 32'(mem[8'h81]), 32'h00);
      chk("t5_mem82", 32'(mem[8'h82]), 32'h00);
      chk("t5_mem83", 32'(mem[8'h83]), 32'h00);
      run_burst(1'b0, 8'h10, 5'd1, 1'b0);
      chk("t5_after_lat", 32'(lat), 32'd5);
      chk("t5_after_data", 32'(rq[0]), 32'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
